// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - key strobe, ALU and display bundle for calc_sequencer
interface calc_sequencer_if;
    logic       digit_stb;
    logic [3:0] digit;
    logic       add_stb;
    logic       sub_stb;
    logic       eq_stb;
    logic       cancel;
    logic [3:0] alu_num1;
    logic [3:0] alu_num2;
    logic       alu_op;
    logic [4:0] alu_result;
    logic [4:0] disp_mag;
    logic       disp_neg;
    logic       done;
    logic       busy;
    logic [2:0] state;

    modport master (
        output digit_stb, digit, add_stb, sub_stb, eq_stb, cancel, alu_result,
        input  alu_num1, alu_num2, alu_op, disp_mag, disp_neg, done, busy, state
    );

    modport slave (
        input  digit_stb, digit, add_stb, sub_stb, eq_stb, cancel, alu_result,
        output alu_num1, alu_num2, alu_op, disp_mag, disp_neg, done, busy, state
    );
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator key sequencer driving a registered ALU
// Optional CALC_SEQ_CHAIN_EN: add/sub in SHOW chains from the displayed result.
module calc_sequencer (
    input logic             clk,
    input logic             clear,
    calc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_OP1   = 3'd0,
        S_OPSEL = 3'd1,
        S_OP2   = 3'd2,
        S_READY = 3'd3,
        S_EXEC  = 3'd4,
        S_CAPT  = 3'd5,
        S_SHOW  = 3'd6
    } state_t;

    state_t     r_state, w_state;
    logic [3:0] r_num1, w_num1;
    logic [3:0] r_num2, w_num2;
    logic       r_op, w_op;
    logic [4:0] r_mag, w_mag;
    logic       r_neg, w_neg;
    logic       r_done, w_done;

    // Only the highest-priority strobe survives decoding.
    logic w_eq, w_sub, w_add, w_dig, w_opkey;
    assign w_eq    = bus.eq_stb;
    assign w_sub   = bus.sub_stb & ~bus.eq_stb;
    assign w_add   = bus.add_stb & ~bus.sub_stb & ~bus.eq_stb;
    assign w_dig   = bus.digit_stb & ~bus.add_stb & ~bus.sub_stb & ~bus.eq_stb;
    assign w_opkey = w_add | w_sub;

    logic [4:0] w_neg_mag;
    assign w_neg_mag = ~bus.alu_result + 5'd1;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_OP1;
            r_num1  <= 4'd0;
            r_num2  <= 4'd0;
            r_op    <= 1'b0;
            r_mag   <= 5'd0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_num1  <= w_num1;
            r_num2  <= w_num2;
            r_op    <= w_op;
            r_mag   <= w_mag;
            r_neg   <= w_neg;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_num1  = r_num1;
        w_num2  = r_num2;
        w_op    = r_op;
        w_mag   = r_mag;
        w_neg   = r_neg;
        w_done  = 1'b0;
        case (r_state)
            S_OP1: begin
                if (w_dig) begin
                    w_num1  = bus.digit;
                    w_state = S_OPSEL;
                end
            end
            S_OPSEL: begin
                if (w_opkey) begin
                    w_op    = w_sub;
                    w_state = S_OP2;
                end else if (w_dig) begin
                    w_num1 = bus.digit;
                end
            end
            S_OP2: begin
                if (w_opkey) begin
                    w_op = w_sub;
                end else if (w_dig) begin
                    w_num2  = bus.digit;
                    w_state = S_READY;
                end
            end
            S_READY: begin
                if (w_eq) begin
                    w_state = S_EXEC;
                end else if (w_opkey) begin
                    w_op = w_sub;
                end else if (w_dig) begin
                    w_num2 = bus.digit;
                end
            end
            S_EXEC: w_state = S_CAPT;
            S_CAPT: begin
                // A borrow means the ALU holds a two's-complement negative.
                if (r_op && (r_num1 < r_num2)) begin
                    w_mag = w_neg_mag;
                    w_neg = 1'b1;
                end else begin
                    w_mag = bus.alu_result;
                    w_neg = 1'b0;
                end
                w_done  = 1'b1;
                w_state = S_SHOW;
            end
            S_SHOW: begin
                if (w_dig) begin
                    w_num1  = bus.digit;
                    w_state = S_OPSEL;
                end
`ifdef CALC_SEQ_CHAIN_EN
                else if (w_opkey && !r_neg && (r_mag <= 5'd15)) begin
                    w_num1  = r_mag[3:0];
                    w_op    = w_sub;
                    w_state = S_OP2;
                end
`endif
            end
            default: w_state = S_OP1;
        endcase
        if (bus.cancel) begin
            w_state = S_OP1;
            w_num1  = 4'd0;
            w_num2  = 4'd0;
            w_op    = 1'b0;
            w_mag   = 5'd0;
            w_neg   = 1'b0;
            w_done  = 1'b0;
        end
    end

    assign bus.alu_num1 = r_num1;
    assign bus.alu_num2 = r_num2;
    assign bus.alu_op   = r_op;
    assign bus.disp_mag = r_mag;
    assign bus.disp_neg = r_neg;
    assign bus.done     = r_done;
    assign bus.busy     = (r_state == S_EXEC) || (r_state == S_CAPT);
    assign bus.state    = r_state;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - randomized and directed bench for calc_sequencer with ALU model
module tb_calc_sequencer;
    logic clk = 1'b0;
    logic clear = 1'b1;
    calc_sequencer_if bus();

    calc_sequencer dut (.clk(clk), .clear(clear), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Registered ALU sharing the clear net with the sequencer.
    always @(posedge clk or posedge clear) begin
        if (clear) bus.alu_result <= 5'd0;
        else if (bus.alu_op) bus.alu_result <= {1'b0, bus.alu_num1} - {1'b0, bus.alu_num2};
        else bus.alu_result <= {1'b0, bus.alu_num1} + {1'b0, bus.alu_num2};
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    int m_state, m_n1, m_n2, m_op, m_mag, m_neg, m_done;

    task automatic m_reset();
        m_state = 0; m_n1 = 0; m_n2 = 0; m_op = 0; m_mag = 0; m_neg = 0; m_done = 0;
    endtask

    // Reference: keys resolved by priority, result by signed integer arithmetic.
    always @(posedge clk or posedge clear) begin
        int key, res;
        if (clear) begin
            m_reset();
        end else begin
            key = bus.eq_stb ? 4 : bus.sub_stb ? 3 : bus.add_stb ? 2 : bus.digit_stb ? 1 : 0;
            m_done = 0;
            if (bus.cancel) m_reset();
            else case (m_state)
                0: if (key == 1) begin m_n1 = bus.digit; m_state = 1; end
                1: if (key == 1) m_n1 = bus.digit;
                   else if (key == 2 || key == 3) begin m_op = key - 2; m_state = 2; end
                2: if (key == 1) begin m_n2 = bus.digit; m_state = 3; end
                   else if (key == 2 || key == 3) m_op = key - 2;
                3: if (key == 4) m_state = 4;
                   else if (key == 1) m_n2 = bus.digit;
                   else if (key == 2 || key == 3) m_op = key - 2;
                4: m_state = 5;
                5: begin
                    res = m_op ? m_n1 - m_n2 : m_n1 + m_n2;
                    m_neg = (res < 0) ? 1 : 0;
                    m_mag = (res < 0) ? -res : res;
                    m_done = 1;
                    m_state = 6;
                end
                6: if (key == 1) begin m_n1 = bus.digit; m_state = 1; end
`ifdef CALC_SEQ_CHAIN_EN
                   else if ((key == 2 || key == 3) && m_neg == 0 && m_mag <= 15) begin
                       m_n1 = m_mag; m_op = key - 2; m_state = 2;
                   end
`endif
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(bus.state), m_state);
            chk("alu_num1", int'(bus.alu_num1), m_n1);
            chk("alu_num2", int'(bus.alu_num2), m_n2);
            chk("alu_op", int'(bus.alu_op), m_op);
            chk("disp_mag", int'(bus.disp_mag), m_mag);
            chk("disp_neg", int'(bus.disp_neg), m_neg);
            chk("done", int'(bus.done), m_done);
            chk("busy", int'(bus.busy), (m_state == 4 || m_state == 5) ? 1 : 0);
        end
    end

    // Called just after a falling edge; returns at the next falling edge.
    task automatic press(input bit ds, input int d, input bit a, input bit s, input bit e, input bit c);
        bus.digit_stb = ds; bus.digit = 4'(d); bus.add_stb = a;
        bus.sub_stb = s; bus.eq_stb = e; bus.cancel = c;
        @(posedge clk);
        @(negedge clk);
        bus.digit_stb = 0; bus.add_stb = 0; bus.sub_stb = 0; bus.eq_stb = 0; bus.cancel = 0;
    endtask

    task automatic dig(input int d); press(1, d, 0, 0, 0, 0); endtask
    task automatic add(); press(0, 0, 1, 0, 0, 0); endtask
    task automatic sub(); press(0, 0, 0, 1, 0, 0); endtask
    task automatic eq(); press(0, 0, 0, 0, 1, 0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) press(0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_result(input string nm, input int mag, input int neg);
        chk({nm, "_done"}, int'(bus.done), 1);
        chk({nm, "_mag"}, int'(bus.disp_mag), mag);
        chk({nm, "_neg"}, int'(bus.disp_neg), neg);
        chk({nm, "_state"}, int'(bus.state), 6);
    endtask

    initial begin
        bus.digit_stb = 0; bus.digit = 0; bus.add_stb = 0; bus.sub_stb = 0;
        bus.eq_stb = 0; bus.cancel = 0;
        @(negedge clk);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_mag", int'(bus.disp_mag), 0);
        @(negedge clk);
        clear = 0;
        chk_en = 1;

        dig(9); add(); dig(7); eq();
        chk("exec_busy", int'(bus.busy), 1);
        chk("exec_done", int'(bus.done), 0);
        idle(1);
        chk("capt_done", int'(bus.done), 0);
        idle(1);
        expect_result("9p7", 16, 0);
        idle(1);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("mag_hold", int'(bus.disp_mag), 16);

        dig(3); sub(); dig(5); eq(); idle(2);
        expect_result("3m5", 2, 1);
        dig(15); sub(); dig(15); eq(); idle(2);
        expect_result("15m15", 0, 0);

        dig(4); dig(6); add(); sub(); dig(2); eq(); idle(2);
        expect_result("corr", 4, 0);

        dig(2); add(); dig(3);
        press(1, 9, 0, 0, 1, 0);
        chk("eq_dig_state", int'(bus.state), 4);
        chk("eq_dig_num2", int'(bus.alu_num2), 3);
        idle(2);
        expect_result("eq_dig", 5, 0);

        dig(1); add(); dig(1); eq();
        #2 clear = 1;
        #1;
        chk("clr_state", int'(bus.state), 0);
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_mag", int'(bus.disp_mag), 0);
        chk("clr_num1", int'(bus.alu_num1), 0);
        @(negedge clk);
        clear = 0;
        for (int i = 0; i < 3; i++) begin
            chk("clr_no_done", int'(bus.done), 0);
            idle(1);
        end

        dig(1); add(); dig(1); eq();
        press(0, 0, 0, 0, 0, 1);
        chk("cancel_state", int'(bus.state), 0);
        chk("cancel_num2", int'(bus.alu_num2), 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("cancel_no_done", int'(bus.done), 0);
        end

        dig(5); add(); dig(4); eq(); idle(2);
        expect_result("5p4", 9, 0);
        add();
`ifdef CALC_SEQ_CHAIN_EN
        chk("chain_state", int'(bus.state), 2);
        chk("chain_num1", int'(bus.alu_num1), 9);
        dig(6); eq(); idle(2);
        expect_result("chain", 15, 0);
        dig(9); add(); dig(9); eq(); idle(2);
        expect_result("9p9", 18, 0);
        add();
        chk("chain_big_state", int'(bus.state), 6);
`else
        chk("nochain_state", int'(bus.state), 6);
        chk("nochain_num1", int'(bus.alu_num1), 5);
`endif

        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            press($urandom_range(0, 99) < 45, $urandom_range(0, 15),
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 20, r < 2);
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
